// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the CPU data-memory port. Reads return data one
//   cycle later (forwarded from the write buffer when it holds the address,
//   otherwise from the backing RAM). Writes are posted into an in-order write
//   buffer that drains into a single-port RAM. Each buffered write needs
//   WR_CYCLES cycles in which the RAM port is free.
//
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous reset, active-low
//   req_i        access request this cycle
//   WE_i         1 = write, 0 = read (qualified by req_i)
//   address_i    word address; values >= 2**ADDR_W are out of range
//   data_i       write data
//   data_o       registered read data (holds when there is no read)
//   stall_o      write not accepted this cycle, CPU must hold the request
//   wb_count_o   registered number of buffered writes pending
//   err_o        registered pulse: previous access was out of range
//   dbg_state_o  drain FSM state (0 = IDLE, 1 = BUSY)
//
// Handshake: a request is presented by holding req_i/WE_i/address_i/data_i
// for a cycle. A write is accepted at the rising edge when stall_o is low;
// while stall_o is high the CPU keeps the same request asserted. Reads and
// out-of-range accesses are always accepted in the cycle they are presented.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int WB_DEPTH  = 4,
    parameter int WR_CYCLES = 3
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          req_i,
    input  logic                          WE_i,
    input  logic [31:0]                   address_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          stall_o,
    output logic [$clog2(WB_DEPTH+1)-1:0] wb_count_o,
    output logic                          err_o,
    output logic                          dbg_state_o
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = $clog2(WB_DEPTH + 1);
    localparam int CYC_W = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [PTR_W:0]   DEPTH_P  = (PTR_W + 1)'(WB_DEPTH);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WR_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } drain_state_t;

    // Storage
    logic [ADDR_W-1:0] r_wb_addr [WB_DEPTH];
    logic [DATA_W-1:0] r_wb_data [WB_DEPTH];
    logic [DATA_W-1:0] r_ram     [2**ADDR_W];

    // State
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    drain_state_t      r_state;
    logic [CYC_W-1:0]  r_cyc;
    logic [DATA_W-1:0] r_data;
    logic              r_err;

    // Combinational
    logic              w_in_range;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rd;
    logic              w_wr_req;
    logic              w_full;
    logic              w_enq;
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic [PTR_W:0]    w_idx;
    logic              w_port_busy;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_in_range = (address_i[31:ADDR_W] == '0);
    assign w_addr     = address_i[ADDR_W-1:0];
    assign w_rd       = req_i && !WE_i && w_in_range;
    assign w_wr_req   = req_i && WE_i && w_in_range;
    assign w_full     = (r_count == CNT_W'(WB_DEPTH));
    // Out-of-range writes are dropped, so they never stall.
    assign stall_o    = w_full && w_wr_req;
    assign w_enq      = w_wr_req && !w_full;

    // Scan valid entries oldest to youngest; a later match overrides an
    // earlier one so the youngest write to the address is forwarded.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        w_idx      = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            w_idx = {1'b0, r_head} + (PTR_W + 1)'(i);
            if (w_idx >= DEPTH_P) begin
                w_idx = w_idx - DEPTH_P;
            end
            if ((CNT_W'(i) < r_count) && (r_wb_addr[w_idx[PTR_W-1:0]] == w_addr)) begin
                w_hit      = 1'b1;
                w_fwd_data = r_wb_data[w_idx[PTR_W-1:0]];
            end
        end
    end

    // A read that misses the buffer owns the RAM port; draining waits.
    assign w_port_busy = w_rd && !w_hit;
    assign w_pop       = (r_state == S_BUSY) && !w_port_busy && (r_cyc == CYC_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
            r_cyc   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);

            if (req_i && !WE_i) begin
                if (!w_in_range) begin
                    r_data <= '0;
                end else if (w_hit) begin
                    r_data <= w_fwd_data;
                end else begin
                    r_data <= r_ram[w_addr];
                end
            end
            r_err <= req_i && !w_in_range;

            case (r_state)
                S_IDLE: begin
                    // The cycle that notices pending work is not a drain cycle.
                    if (r_count != '0) begin
                        r_state <= S_BUSY;
                        r_cyc   <= '0;
                    end
                end
                S_BUSY: begin
                    if (!w_port_busy) begin
                        if (r_cyc == CYC_LAST) begin
                            r_cyc <= '0;
                            // Only the popped entry left and nothing arriving.
                            if ((r_count == CNT_W'(1)) && !w_enq) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cyc <= r_cyc + CYC_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= '0;
                end
            endcase
        end
    end

    // Buffer payload and RAM carry no reset: validity is tracked by the
    // pointers and count, and RAM contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_wb_addr[r_tail] <= w_addr;
            r_wb_data[r_tail] <= data_i;
        end
        if (w_pop) begin
            r_ram[r_wb_addr[r_head]] <= r_wb_data[r_head];
        end
    end

    assign data_o      = r_data;
    assign wb_count_o  = r_count;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int CNT_W = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             req_i;
    logic             WE_i;
    logic [31:0]      address_i;
    logic [31:0]      data_i;
    logic [31:0]      data_o;
    logic             stall_o;
    logic [CNT_W-1:0] wb_count_o;
    logic             err_o;
    logic             dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    bit   [31:0] model [1024];

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    data_mem_responder #(
        .DATA_W(32), .ADDR_W(10), .WB_DEPTH(4), .WR_CYCLES(3)
    ) dut (
        .CLK(CLK), .RST(RST), .req_i(req_i), .WE_i(WE_i),
        .address_i(address_i), .data_i(data_i), .data_o(data_o),
        .stall_o(stall_o), .wb_count_o(wb_count_o), .err_o(err_o),
        .dbg_state_o(dbg_state_o)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input string tag);
        req_i     = 1'b1;
        WE_i      = 1'b0;
        address_i = addr;
        data_i    = $urandom;
        exp_q.push_back((addr < 32'd1024) ? model[addr[9:0]] : 32'd0);
        #1;
        check({tag, "_stall"}, stall_o, 0);
        tick();
        check(tag, data_o, exp_q.pop_front());
        check({tag, "_err"}, err_o, (addr >= 32'd1024));
        req_i = 1'b0;
    endtask

    // One write cycle with a bench-predicted stall and post-edge count.
    // commit=0 marks a write that is expected to be lost (reset before drain).
    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input bit exp_stall, input int exp_cnt, input bit commit,
                      input string tag);
        req_i     = 1'b1;
        WE_i      = 1'b1;
        address_i = addr;
        data_i    = data;
        #1;
        check({tag, "_stall"}, stall_o, exp_stall);
        if (!exp_stall && addr < 32'd1024 && commit) begin
            model[addr[9:0]] = data;
        end
        tick();
        check({tag, "_cnt"}, wb_count_o, exp_cnt);
        check({tag, "_err"}, err_o, (addr >= 32'd1024));
        req_i = 1'b0;
    endtask

    // Write that follows the stall handshake without predicting it.
    task automatic wr_any(input logic [31:0] addr, input logic [31:0] data);
        int guard;
        guard     = 0;
        req_i     = 1'b1;
        WE_i      = 1'b1;
        address_i = addr;
        data_i    = data;
        #1;
        while (stall_o && guard < 50) begin
            @(posedge CLK);
            #2;
            guard++;
        end
        check("wr_any_stall_bound", (guard < 50), 1);
        model[addr[9:0]] = data;
        tick();
        req_i = 1'b0;
    endtask

    task automatic idle(input int exp_cnt, input string tag);
        req_i = 1'b0;
        tick();
        check({tag, "_cnt"}, wb_count_o, exp_cnt);
    endtask

    task automatic wait_empty(input string tag);
        int g;
        g     = 0;
        req_i = 1'b0;
        while (wb_count_o != '0 && g < 200) begin
            tick();
            g++;
        end
        check(tag, wb_count_o, 0);
        check({tag, "_state"}, dbg_state_o, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        RST       = 1'b0;
        req_i     = 1'b0;
        WE_i      = 1'b0;
        address_i = '0;
        data_i    = '0;
        #2;
        check("rst_data", data_o, 0);
        check("rst_cnt", wb_count_o, 0);
        check("rst_err", err_o, 0);
        check("rst_stall", stall_o, 0);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;
        tick();

        // Preload RAM locations used by later reads.
        wr_any(32'd3,  32'h3333_3333);
        wr_any(32'd20, 32'hAAAA_0020);
        wr_any(32'd21, 32'hAAAA_0021);
        wr_any(32'd22, 32'hAAAA_0022);
        wait_empty("preload_drain");

        // 1: forwarding from buffer, then from RAM.
        wr(32'd5, 32'hDEAD_BEEF, 0, 1, 1, "t1_wr");
        rd(32'd5, "t1_fwd");
        wait_empty("t1_drain");
        rd(32'd5, "t1_ram");

        // 2: fill to depth, stall only while full, order preserved.
        wr(32'd100, 32'h0000_1000, 0, 1, 1, "t2_w0");
        wr(32'd101, 32'h0000_1001, 0, 2, 1, "t2_w1");
        wr(32'd102, 32'h0000_1002, 0, 3, 1, "t2_w2");
        wr(32'd103, 32'h0000_1003, 0, 4, 1, "t2_w3");
        wr(32'd104, 32'h0000_1004, 1, 3, 1, "t2_w4_stalled");
        wr(32'd104, 32'h0000_1004, 0, 4, 1, "t2_w4");
        wait_empty("t2_drain");
        for (int i = 0; i < 5; i++) begin
            rd(32'd100 + 32'(i), "t2_rb");
        end

        // 3: duplicate address, youngest wins, FIFO drain leaves youngest.
        wr(32'd9, 32'h0000_0011, 0, 1, 1, "t3_w0");
        wr(32'd9, 32'h0000_0022, 0, 2, 1, "t3_w1");
        rd(32'd9, "t3_fwd");
        wait_empty("t3_drain");
        rd(32'd9, "t3_ram");

        // 4: read misses pause the drain; pop lands three free cycles later.
        wr(32'd7, 32'h0000_0077, 0, 1, 1, "t4_wr");
        for (int i = 0; i < 4; i++) begin
            rd(32'd3, "t4_miss");
            check("t4_hold_cnt", wb_count_o, 1);
        end
        idle(1, "t4_resume0");
        idle(1, "t4_resume1");
        idle(0, "t4_pop");
        rd(32'd7, "t4_ram");

        // 5: out-of-range read and write (write offered while buffer full).
        rd(32'h0000_0400, "t5_rd_oor");
        idle(0, "t5_idle");
        check("t5_err_pulse", err_o, 0);
        wr(32'd40, 32'h0000_0040, 0, 1, 1, "t5_f0");
        wr(32'd41, 32'h0000_0041, 0, 2, 1, "t5_f1");
        wr(32'd42, 32'h0000_0042, 0, 3, 1, "t5_f2");
        wr(32'd43, 32'h0000_0043, 0, 4, 1, "t5_f3");
        wr(32'h0000_0400, 32'hBAD0_BAD0, 0, 3, 1, "t5_wr_oor");
        idle(3, "t5_idle2");
        check("t5_err_pulse2", err_o, 0);
        wait_empty("t5_drain");
        rd(32'd40, "t5_rb");

        // Random mix on a few addresses with forwarding/drain interleaving.
        for (int i = 0; i < 4; i++) begin
            wr_any(32'd200 + 32'(i), $urandom);
        end
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                wr_any(32'd200 + 32'($urandom_range(0, 3)), $urandom);
            end else begin
                rd(32'd200 + 32'($urandom_range(0, 3)), "rand_rd");
            end
        end
        wait_empty("rand_drain");
        for (int i = 0; i < 4; i++) begin
            rd(32'd200 + 32'(i), "rand_rb");
        end

        // 6: reset mid-drain discards pending writes, RAM keeps old data.
        rd(32'd20, "t6_pre");
        wr(32'd20, ~model[20], 0, 1, 0, "t6_w0");
        wr(32'd21, ~model[21], 0, 2, 0, "t6_w1");
        wr(32'd22, ~model[22], 0, 3, 0, "t6_w2");
        #2;
        RST = 1'b0;
        #1;
        check("t6_rst_data", data_o, 0);
        check("t6_rst_cnt", wb_count_o, 0);
        check("t6_rst_err", err_o, 0);
        check("t6_rst_stall", stall_o, 0);
        check("t6_rst_state", dbg_state_o, 0);
        #10;
        check("t6_rst_cnt_hold", wb_count_o, 0);
        RST = 1'b1;
        tick();
        idle(0, "t6_after");
        rd(32'd20, "t6_rb20");
        rd(32'd21, "t6_rb21");
        rd(32'd22, "t6_rb22");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
